// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing generator with four run-time selectable RGB565 test patterns.
module vga_pattern_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int H_ACT     = 640,
  parameter int H_FP      = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int V_ACT     = 480,
  parameter int V_FP      = 10,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int NUM_BARS  = 8,
  parameter int CHK_LOG2  = 5,
  parameter int GRID_LOG2 = 4
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [1:0]  I_mode,
  input  logic [15:0] I_solid_rgb,
  output logic [4:0]  O_red,
  output logic [5:0]  O_green,
  output logic [4:0]  O_blue,
  output logic        O_hs,
  output logic        O_vs,
  output logic        O_de,
  output logic        O_frame_start
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int H_ST = H_SYNC + H_BP;
  localparam int V_ST = V_SYNC + V_BP;
  localparam int BAR_W = H_ACT / NUM_BARS;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [1:0]    mode_q;
  logic [15:0]   bar_pos, bar_idx, x, y, bar_rgb, pix;
  logic          pix_ce, origin, act, grid;
  assign pix_ce = div_cnt == DW'(CLK_DIV - 1);
  assign origin = h_cnt == '0 && v_cnt == '0;
  assign act = int'(h_cnt) >= H_ST && int'(h_cnt) < H_ST + H_ACT &&
               int'(v_cnt) >= V_ST && int'(v_cnt) < V_ST + V_ACT;
  assign x = 16'(h_cnt) - 16'(H_ST);
  assign y = 16'(v_cnt) - 16'(V_ST);
  assign grid = x[GRID_LOG2-1:0] == '0 || y[GRID_LOG2-1:0] == '0 ||
                x == 16'(H_ACT - 1) || y == 16'(V_ACT - 1);
  always_comb begin
    bar_rgb = 16'h0000;
    case (bar_idx[2:0])
      3'd0: bar_rgb = 16'hF800;
      3'd1: bar_rgb = 16'h07E0;
      3'd2: bar_rgb = 16'h001F;
      3'd3: bar_rgb = 16'hFFFF;
      3'd4: bar_rgb = 16'h0000;
      3'd5: bar_rgb = 16'hFFE0;
      3'd6: bar_rgb = 16'hF81F;
      default: bar_rgb = 16'h07FF;
    endcase
  end
  // Checker squares are white where the x and y square parities agree, so (0,0) is white.
  assign pix = !act          ? 16'h0000 :
               mode_q == 2'd0 ? bar_rgb :
               mode_q == 2'd1 ? ((x[CHK_LOG2] ^ y[CHK_LOG2]) ? 16'h0000 : 16'hFFFF) :
               mode_q == 2'd2 ? (grid ? I_solid_rgb : 16'h0000) : I_solid_rgb;
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      mode_q <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
      {O_red, O_green, O_blue} <= '0;
      O_de <= 1'b0;
      O_frame_start <= 1'b0;
      O_hs <= ~HS_POL;
      O_vs <= ~VS_POL;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + DW'(1);
      O_frame_start <= pix_ce && origin;
      if (pix_ce) begin
        h_cnt <= h_cnt == HW'(H_TOT - 1) ? '0 : h_cnt + HW'(1);
        if (h_cnt == HW'(H_TOT - 1))
          v_cnt <= v_cnt == VW'(V_TOT - 1) ? '0 : v_cnt + VW'(1);
        if (origin)
          mode_q <= I_mode;
        // Bar tracking by counting; the last bar absorbs any remainder pixels.
        if (!act) begin
          bar_pos <= '0;
          bar_idx <= '0;
        end else if (bar_pos == 16'(BAR_W - 1) && bar_idx != 16'(NUM_BARS - 1)) begin
          bar_pos <= '0;
          bar_idx <= bar_idx + 16'd1;
        end else begin
          bar_pos <= bar_pos + 16'd1;
        end
        {O_red, O_green, O_blue} <= pix;
        O_de <= act;
        O_hs <= int'(h_cnt) < H_SYNC ? HS_POL : ~HS_POL;
        O_vs <= int'(v_cnt) < V_SYNC ? VS_POL : ~VS_POL;
      end
    end
  end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks of timing, patterns, mode latching and reset on two small-timing instances.
module tb_vga_pattern_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd0;
  logic [15:0] solid = 16'h1234;
  logic [4:0] red_a, blue_a, red_b, blue_b;
  logic [5:0] green_a, green_b;
  logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  logic [15:0] rgb_a, rgb_b;
  int compared = 0, mismatched = 0;
  logic [15:0] ca_rgb [0:726];
  logic ca_de [0:726], ca_hs [0:726], ca_vs [0:726], ca_fs [0:726];
  logic [15:0] cb_rgb [0:385];
  logic cb_de [0:385], cb_hs [0:385], cb_fs [0:385];
  assign rgb_a = {red_a, green_a, blue_a};
  assign rgb_b = {red_b, green_b, blue_b};
  always #5 clk = ~clk;
  // A: 33 px x 11 lines, 2 clk per pixel, active 24x6 starting at (7,4), 3 bars of 8
  vga_pattern_gen #(.CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_ACT(24), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .NUM_BARS(3), .CHK_LOG2(2), .GRID_LOG2(2)) dut_a (
    .I_clk(clk), .I_rst_n(rst_a), .I_mode(mode_a), .I_solid_rgb(solid),
    .O_red(red_a), .O_green(green_a), .O_blue(blue_a), .O_hs(hs_a), .O_vs(vs_a),
    .O_de(de_a), .O_frame_start(fs_a));
  // B: 35 px x 11 lines, 1 clk per pixel, HS active high, 8 bars of 3 with last bar 5 px wide
  vga_pattern_gen #(.CLK_DIV(1), .H_SYNC(4), .H_BP(3), .H_ACT(26), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACT(6), .V_FP(1), .HS_POL(1'b1), .VS_POL(1'b0),
    .NUM_BARS(8), .CHK_LOG2(2), .GRID_LOG2(2)) dut_b (
    .I_clk(clk), .I_rst_n(rst_b), .I_mode(mode_b), .I_solid_rgb(solid),
    .O_red(red_b), .O_green(green_b), .O_blue(blue_b), .O_hs(hs_b), .O_vs(vs_b),
    .O_de(de_b), .O_frame_start(fs_b));
  function automatic int pa(input int x, input int y);
    return 2 * ((y + 4) * 33 + x + 7);
  endfunction
  task automatic capture_a(input bit fresh, input int sw_at, input logic [1:0] sw_mode);
    int n = 0;
    if (fresh) @(negedge clk);
    while (fs_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    compared++;
    if (fs_a !== 1'b1) begin mismatched++; $display("FAIL cap_a_frame_start: got %b want 1", fs_a); end
    for (int i = 0; i <= 726; i++) begin
      ca_rgb[i] = rgb_a; ca_de[i] = de_a; ca_hs[i] = hs_a; ca_vs[i] = vs_a; ca_fs[i] = fs_a;
      if (i == sw_at) mode_a = sw_mode;
      if (i < 726) @(negedge clk);
    end
  endtask
  task automatic capture_b();
    int n = 0;
    while (fs_b !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    compared++;
    if (fs_b !== 1'b1) begin mismatched++; $display("FAIL cap_b_frame_start: got %b want 1", fs_b); end
    for (int i = 0; i <= 385; i++) begin
      cb_rgb[i] = rgb_b; cb_de[i] = de_b; cb_hs[i] = hs_b; cb_fs[i] = fs_b;
      if (i < 385) @(negedge clk);
    end
  endtask
  task automatic test_reset();
    int ea = 0, eb = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (10) @(negedge clk);
    compared++;
    if ({rgb_a, de_a, hs_a, vs_a, fs_a} !== {16'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      mismatched++; $display("FAIL reset_a: got rgb=%h de=%b hs=%b vs=%b fs=%b want 0000 0 1 1 0", rgb_a, de_a, hs_a, vs_a, fs_a);
    end
    compared++;
    if ({rgb_b, de_b, hs_b, vs_b} !== {16'h0, 1'b0, 1'b0, 1'b1}) begin
      mismatched++; $display("FAIL reset_b: got rgb=%h de=%b hs=%b vs=%b want 0000 0 0 1", rgb_b, de_b, hs_b, vs_b);
    end
    rst_a = 1'b1; rst_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (fs_a === 1'b1 && ea == 0) ea = k;
      if (fs_b === 1'b1 && eb == 0) eb = k;
    end
    compared++;
    if (ea != 2) begin mismatched++; $display("FAIL first_fs_a: got %0d edges want 2", ea); end
    compared++;
    if (eb != 1) begin mismatched++; $display("FAIL first_fs_b: got %0d edges want 1", eb); end
  endtask
  task automatic test_timing();
    int hl = 0, vl = 0, dh = 0, fsn = 0, hr = 0, pm = 0;
    mode_a = 2'd3;
    capture_a(1'b1, -1, 2'd0);
    for (int i = 0; i < 726; i++) begin
      hl += int'(ca_hs[i] == 1'b0); vl += int'(ca_vs[i] == 1'b0);
      dh += int'(ca_de[i] == 1'b1); fsn += int'(ca_fs[i] == 1'b1);
      if (i > 0 && ca_hs[i] === 1'b1 && ca_hs[i-1] === 1'b0) hr++;
    end
    for (int v = 0; v < 11; v++)
      for (int h = 0; h < 33; h++) begin
        automatic int p = 2 * (v * 33 + h);
        automatic logic a = h >= 7 && h < 31 && v >= 4 && v < 10;
        if (ca_de[p] !== a || ca_de[p+1] !== a || ca_rgb[p] !== (a ? 16'h1234 : 16'h0000)) pm++;
      end
    compared++; if (hl != 88) begin mismatched++; $display("FAIL hs_low_clks: got %0d want 88", hl); end
    compared++; if (hr != 11) begin mismatched++; $display("FAIL hs_periods: got %0d want 11", hr); end
    compared++; if (ca_hs[0] !== 1'b0 || ca_hs[7] !== 1'b0 || ca_hs[8] !== 1'b1) begin
      mismatched++; $display("FAIL hs_edges: got %b%b%b want 001", ca_hs[0], ca_hs[7], ca_hs[8]); end
    compared++; if (vl != 132) begin mismatched++; $display("FAIL vs_low_clks: got %0d want 132", vl); end
    compared++; if (dh != 288) begin mismatched++; $display("FAIL de_high_clks: got %0d want 288", dh); end
    compared++; if (fsn != 1 || ca_fs[726] !== 1'b1) begin
      mismatched++; $display("FAIL frame_period: got %0d pulses next=%b want 1 1", fsn, ca_fs[726]); end
    compared++; if (pm != 0) begin mismatched++; $display("FAIL solid_de_map: got %0d bad pixels want 0", pm); end
  endtask
  task automatic test_bars();
    int xs [8] = '{0, 7, 8, 15, 16, 23, -1, 24};
    logic [15:0] ex [8] = '{16'hF800, 16'hF800, 16'h07E0, 16'h07E0, 16'h001F, 16'h001F, 16'h0000, 16'h0000};
    mode_a = 2'd0;
    capture_a(1'b1, -1, 2'd0);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (ca_rgb[pa(xs[i], 2)] !== ex[i]) begin
        mismatched++; $display("FAIL bar_a x=%0d: got %h want %h", xs[i], ca_rgb[pa(xs[i], 2)], ex[i]);
      end
    end
  endtask
  task automatic test_checker();
    int xs [5] = '{0, 4, 4, 8, 8};
    int ys [5] = '{0, 0, 4, 4, 0};
    logic [15:0] ex [5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    mode_a = 2'd1;
    capture_a(1'b1, -1, 2'd0);
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (ca_rgb[pa(xs[i], ys[i])] !== ex[i]) begin
        mismatched++; $display("FAIL checker (%0d,%0d): got %h want %h", xs[i], ys[i], ca_rgb[pa(xs[i], ys[i])], ex[i]);
      end
    end
  endtask
  task automatic test_grid();
    int xs [6] = '{0, 1, 1, 23, 22, 2};
    int ys [6] = '{1, 1, 4, 1, 5, 2};
    logic [15:0] ex [6] = '{16'h1234, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 16'h0000};
    mode_a = 2'd2;
    capture_a(1'b1, -1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (ca_rgb[pa(xs[i], ys[i])] !== ex[i]) begin
        mismatched++; $display("FAIL grid (%0d,%0d): got %h want %h", xs[i], ys[i], ca_rgb[pa(xs[i], ys[i])], ex[i]);
      end
    end
  endtask
  task automatic test_mode_switch();
    mode_a = 2'd0;
    capture_a(1'b1, 2 * (6 * 33), 2'd3);
    compared++;
    if (ca_rgb[pa(0, 5)] !== 16'hF800 || ca_rgb[pa(23, 5)] !== 16'h001F) begin
      mismatched++; $display("FAIL switch_same_frame: got %h %h want F800 001F", ca_rgb[pa(0, 5)], ca_rgb[pa(23, 5)]);
    end
    capture_a(1'b0, -1, 2'd0);
    compared++;
    if (ca_rgb[pa(0, 0)] !== 16'h1234 || ca_rgb[pa(10, 3)] !== 16'h1234) begin
      mismatched++; $display("FAIL switch_next_frame: got %h %h want 1234 1234", ca_rgb[pa(0, 0)], ca_rgb[pa(10, 3)]);
    end
  endtask
  task automatic test_clkdiv1_pol();
    int n = 0, e = 0, hh = 0;
    int xs [7] = '{0, 2, 3, 20, 21, 25, 26};
    logic [15:0] ex [7] = '{16'hF800, 16'hF800, 16'h07E0, 16'hF81F, 16'h07FF, 16'h07FF, 16'h0000};
    while (fs_b !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (5 * 35 + 10) @(negedge clk);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({hs_b, de_b, rgb_b, fs_b} !== {1'b0, 1'b0, 16'h0, 1'b0}) begin
      mismatched++; $display("FAIL midreset_b: got hs=%b de=%b rgb=%h fs=%b want 0 0 0000 0", hs_b, de_b, rgb_b, fs_b);
    end
    rst_b = 1'b1;
    for (int k = 1; k <= 10 && e == 0; k++) begin
      @(negedge clk);
      if (fs_b === 1'b1) e = k;
    end
    compared++;
    if (e != 1) begin mismatched++; $display("FAIL midreset_fs_b: got %0d edges want 1", e); end
    capture_b();
    for (int i = 0; i < 385; i++) hh += int'(cb_hs[i] == 1'b1);
    compared++;
    if (hh != 44 || cb_hs[0] !== 1'b1 || cb_hs[3] !== 1'b1 || cb_hs[4] !== 1'b0) begin
      mismatched++; $display("FAIL hs_pol_b: got %0d high %b%b%b want 44 110", hh, cb_hs[0], cb_hs[3], cb_hs[4]);
    end
    compared++;
    if (cb_fs[385] !== 1'b1 || cb_fs[384] !== 1'b0) begin
      mismatched++; $display("FAIL frame_period_b: got %b%b want 01", cb_fs[384], cb_fs[385]);
    end
    for (int i = 0; i < 7; i++) begin
      compared++;
      if (cb_rgb[4 * 35 + xs[i] + 7] !== ex[i]) begin
        mismatched++; $display("FAIL bar_b x=%0d: got %h want %h", xs[i], cb_rgb[4 * 35 + xs[i] + 7], ex[i]);
      end
    end
    compared++;
    if (cb_de[4 * 35 + 6] !== 1'b0 || cb_de[4 * 35 + 7] !== 1'b1 || cb_de[4 * 35 + 33] !== 1'b0) begin
      mismatched++; $display("FAIL de_edges_b: got %b%b%b want 010", cb_de[4 * 35 + 6], cb_de[4 * 35 + 7], cb_de[4 * 35 + 33]);
    end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_checker();
    test_grid();
    test_mode_switch();
    test_clkdiv1_pol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
